// File: rtl/mat_pkg.sv
// Shared types for the matrix cache: element/row types and the loader state encoding.
// Row types use the default geometry; parameterised blocks build their own packed arrays.
package mat_pkg;

  localparam int unsigned DefFpSize    = 16;
  localparam int unsigned DefWidth     = 128;
  localparam int unsigned DefCacheSize = 256;

  typedef logic [DefFpSize-1:0] fp_t;
  typedef fp_t [DefWidth-1:0]   row_t;

  typedef enum logic [1:0] {
    StIdle,
    StFill,
    StWrite,
    StDone
  } ld_state_e;

endpackage

// File: rtl/mat_row_packer.sv
// Lane counter plus row buffer: shifts one element into lane col per enable.
// o_row_next already includes the element being accepted this cycle.
module mat_row_packer
  import mat_pkg::*;
#(
  parameter int unsigned WIDTH  = DefWidth,
  parameter int unsigned FPSIZE = DefFpSize
) (
  input  logic                           i_clock,
  input  logic                           i_reset,
  input  logic                           i_clear,
  input  logic                           i_shift,
  input  logic [FPSIZE-1:0]              i_data,
  output logic [WIDTH-1:0][FPSIZE-1:0]   o_row_next,
  output logic                           o_full
);

  localparam int unsigned ColW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [ColW-1:0]               r_col;
  logic [WIDTH-1:0][FPSIZE-1:0]  r_buf;
  logic [WIDTH-1:0][FPSIZE-1:0]  w_buf_next;

  always_comb begin
    w_buf_next = r_buf;
    if (i_shift) begin
      w_buf_next[r_col] = i_data;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_col <= '0;
      r_buf <= '0;
    end else begin
      if (i_clear) begin
        r_col <= '0;
      end else if (i_shift) begin
        r_col <= r_col + 1'b1;
      end
      r_buf <= w_buf_next;
    end
  end

  // Full means the element arriving now lands in the last lane.
  assign o_full     = (r_col == ColW'(WIDTH - 1));
  assign o_row_next = w_buf_next;

endmodule

// File: rtl/mat_cache_loader.sv
// Packs a valid/ready element stream into cache rows and writes them to consecutive
// (wrapping) row addresses starting at a programmed base.
module mat_cache_loader
  import mat_pkg::*;
#(
  parameter int unsigned WIDTH     = DefWidth,
  parameter int unsigned CACHESIZE = DefCacheSize,
  parameter int unsigned CACHEADDR = $clog2(CACHESIZE),
  parameter int unsigned FPSIZE    = DefFpSize
) (
  input  logic                           i_clock,
  input  logic                           i_reset,
  input  logic                           i_start,
  input  logic [CACHEADDR-1:0]           i_base_addr,
  input  logic [CACHEADDR:0]             i_num_rows,
  input  logic                           i_in_valid,
  input  logic [FPSIZE-1:0]              i_in_data,
  output logic                           o_in_ready,
  output logic                           o_wr_en,
  output logic [CACHEADDR-1:0]           o_wr_addr,
  output logic [WIDTH-1:0][FPSIZE-1:0]   o_wr_data,
  output logic                           o_busy,
  output logic                           o_done
);

  ld_state_e                     r_state;
  logic [CACHEADDR-1:0]          r_base;
  logic [CACHEADDR:0]            r_num_rows;
  logic [CACHEADDR:0]            r_row;
  logic                          r_in_ready;
  logic                          r_wr_en;
  logic [CACHEADDR-1:0]          r_wr_addr;
  logic [WIDTH-1:0][FPSIZE-1:0]  r_wr_data;
  logic                          r_busy;
  logic                          r_done;

  logic                          w_hs;
  logic                          w_full;
  logic                          w_clear;
  logic [CACHEADDR:0]            w_row_inc;
  logic [WIDTH-1:0][FPSIZE-1:0]  w_row_next;

  assign w_hs      = i_in_valid && r_in_ready;
  assign w_clear   = ((r_state == StIdle) && i_start) || (r_state == StWrite);
  assign w_row_inc = r_row + 1'b1;

  mat_row_packer #(
    .WIDTH  (WIDTH),
    .FPSIZE (FPSIZE)
  ) u_packer (
    .i_clock    (i_clock),
    .i_reset    (i_reset),
    .i_clear    (w_clear),
    .i_shift    (w_hs),
    .i_data     (i_in_data),
    .o_row_next (w_row_next),
    .o_full     (w_full)
  );

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state    <= StIdle;
      r_base     <= '0;
      r_num_rows <= '0;
      r_row      <= '0;
      r_in_ready <= 1'b0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_wr_en <= 1'b0;
      r_done  <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (i_start) begin
            r_base     <= i_base_addr;
            r_num_rows <= i_num_rows;
            r_row      <= '0;
            r_busy     <= 1'b1;
            if (i_num_rows == '0) begin
              r_state <= StDone;
              r_done  <= 1'b1;
            end else begin
              r_state    <= StFill;
              r_in_ready <= 1'b1;
            end
          end
        end
        StFill: begin
          if (w_hs && w_full) begin
            r_state    <= StWrite;
            r_in_ready <= 1'b0;
            r_wr_en    <= 1'b1;
            // Address arithmetic in CACHEADDR bits gives the modulo wrap for free.
            r_wr_addr  <= r_base + r_row[CACHEADDR-1:0];
            r_wr_data  <= w_row_next;
          end
        end
        StWrite: begin
          r_row <= w_row_inc;
          if (w_row_inc == r_num_rows) begin
            r_state <= StDone;
            r_done  <= 1'b1;
          end else begin
            r_state    <= StFill;
            r_in_ready <= 1'b1;
          end
        end
        StDone: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state    <= StIdle;
          r_in_ready <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  assign o_in_ready = r_in_ready;
  assign o_wr_en    = r_wr_en;
  assign o_wr_addr  = r_wr_addr;
  assign o_wr_data  = r_wr_data;
  assign o_busy     = r_busy;
  assign o_done     = r_done;

endmodule

// File: tb/tb_mat_cache_loader.sv
// Bench for mat_cache_loader at WIDTH=4, CACHESIZE=8, FPSIZE=16: an element-queue model
// checked every cycle, plus literal expectations per directed scenario.
module tb_mat_cache_loader;

  localparam int unsigned WIDTH     = 4;
  localparam int unsigned CACHESIZE = 8;
  localparam int unsigned CACHEADDR = 3;
  localparam int unsigned FPSIZE    = 16;

  logic                          clk = 1'b0;
  logic                          i_reset = 1'b1;
  logic                          i_start = 1'b0;
  logic [CACHEADDR-1:0]          i_base_addr = '0;
  logic [CACHEADDR:0]            i_num_rows = '0;
  logic                          i_in_valid = 1'b0;
  logic [FPSIZE-1:0]             i_in_data = '0;
  logic                          o_in_ready;
  logic                          o_wr_en;
  logic [CACHEADDR-1:0]          o_wr_addr;
  logic [WIDTH-1:0][FPSIZE-1:0]  o_wr_data;
  logic                          o_busy;
  logic                          o_done;

  mat_cache_loader #(
    .WIDTH     (WIDTH),
    .CACHESIZE (CACHESIZE),
    .CACHEADDR (CACHEADDR),
    .FPSIZE    (FPSIZE)
  ) dut (
    .i_clock     (clk),
    .i_reset     (i_reset),
    .i_start     (i_start),
    .i_base_addr (i_base_addr),
    .i_num_rows  (i_num_rows),
    .i_in_valid  (i_in_valid),
    .i_in_data   (i_in_data),
    .o_in_ready  (o_in_ready),
    .o_wr_en     (o_wr_en),
    .o_wr_addr   (o_wr_addr),
    .o_wr_data   (o_wr_data),
    .o_busy      (o_busy),
    .o_done      (o_done)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Inputs as seen by the DUT at each rising edge.
  int                 cyc = 0;
  logic               s_reset = 1'b1;
  logic               s_start = 1'b0;
  logic [CACHEADDR-1:0] s_base = '0;
  logic [CACHEADDR:0]   s_rows = '0;
  logic               s_valid = 1'b0;
  logic [FPSIZE-1:0]  s_data = '0;

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    s_reset <= i_reset;
    s_start <= i_start;
    s_base  <= i_base_addr;
    s_rows  <= i_num_rows;
    s_valid <= i_in_valid;
    s_data  <= i_in_data;
  end

  // Model: a load is a count of rows; elements queue up until a row's worth is present.
  bit                           m_filling, m_writing, m_done;
  int                           m_base, m_rows, m_written;
  logic [FPSIZE-1:0]            m_cur[$];
  logic [CACHEADDR-1:0]         e_addr;
  logic [WIDTH-1:0][FPSIZE-1:0] e_data;

  // Observed writes/dones for the literal scenario checks.
  logic [CACHEADDR-1:0]         wlog_addr[$];
  logic [63:0]                  wlog_data[$];
  int                           done_count = 0;
  int                           done_cyc = 0;

  always @(negedge clk) begin
    if (s_reset) begin
      m_filling = 0; m_writing = 0; m_done = 0;
      m_written = 0; m_cur.delete();
      e_addr = '0; e_data = '0;
    end else if (m_done) begin
      m_done = 0;
    end else if (m_writing) begin
      m_writing = 0;
      m_written++;
      if (m_written == m_rows) m_done = 1;
      else m_filling = 1;
    end else if (m_filling) begin
      if (s_valid) begin
        m_cur.push_back(s_data);
        if (m_cur.size() == WIDTH) begin
          m_filling = 0;
          m_writing = 1;
          e_addr = CACHEADDR'((m_base + m_written) % CACHESIZE);
          for (int k = 0; k < WIDTH; k++) e_data[k] = m_cur[k];
          m_cur.delete();
        end
      end
    end else if (s_start) begin
      m_base = int'(s_base);
      m_rows = int'(s_rows);
      m_written = 0;
      if (m_rows == 0) m_done = 1;
      else m_filling = 1;
    end

    chk("in_ready", 64'(o_in_ready), 64'(m_filling));
    chk("wr_en",    64'(o_wr_en),    64'(m_writing));
    chk("done",     64'(o_done),     64'(m_done));
    chk("busy",     64'(o_busy),     64'(m_filling | m_writing | m_done));
    chk("wr_addr",  64'(o_wr_addr),  64'(e_addr));
    chk("wr_data",  64'(o_wr_data),  64'(e_data));

    if (o_wr_en === 1'b1) begin
      wlog_addr.push_back(o_wr_addr);
      wlog_data.push_back(64'(o_wr_data));
    end
    if (o_done === 1'b1) begin
      done_count++;
      done_cyc = cyc;
    end
  end

  int hs_cyc = 0;
  int start_cyc = 0;

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic start_load(input logic [CACHEADDR-1:0] base, input logic [CACHEADDR:0] rows);
    i_start     = 1'b1;
    i_base_addr = base;
    i_num_rows  = rows;
    start_cyc   = cyc;
    @(negedge clk);
    i_start     = 1'b0;
    // Later changes must not affect the running load.
    i_base_addr = ~base;
    i_num_rows  = rows + 1'b1;
  endtask

  task automatic send(input logic [FPSIZE-1:0] d);
    bit got = 0;
    i_in_valid = 1'b1;
    i_in_data  = d;
    for (int n = 0; n < 50; n++) begin
      if (o_in_ready === 1'b1) begin
        hs_cyc = cyc;
        got = 1;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    i_in_valid = 1'b0;
    if (!got) chk("send_timeout", 64'(got), 64'd1);
  endtask

  task automatic wait_done(input int prev);
    bit got = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      #1;
      if (done_count > prev) begin
        got = 1;
        break;
      end
    end
    if (!got) chk("done_timeout", 64'(got), 64'd1);
  endtask

  initial begin
    int prev;

    // Reset idle: two reset cycles, then in_valid alone must not raise in_ready.
    idle(2);
    i_reset = 1'b0;
    i_in_valid = 1'b1;
    i_in_data  = 16'hDEAD;
    idle(3);
    chk("rst_in_ready", 64'(o_in_ready), 64'd0);
    chk("rst_busy", 64'(o_busy), 64'd0);
    chk("rst_wr_data", 64'(o_wr_data), 64'd0);
    i_in_valid = 1'b0;
    idle(1);

    // Single row at base 3.
    wlog_addr.delete(); wlog_data.delete();
    prev = done_count;
    start_load(3'd3, 4'd1);
    send(16'h1111); send(16'h2222); send(16'h3333); send(16'h4444);
    wait_done(prev);
    chk("s1_nwr", 64'(wlog_addr.size()), 64'd1);
    if (wlog_addr.size() == 1) begin
      chk("s1_addr", 64'(wlog_addr[0]), 64'd3);
      chk("s1_data", wlog_data[0], 64'h4444_3333_2222_1111);
    end
    chk("s1_done_lat", 64'(done_cyc - hs_cyc), 64'd2);
    chk("s1_ndone", 64'(done_count - prev), 64'd1);
    idle(2);

    // Wrap with bubbles: base 6, three rows.
    wlog_addr.delete(); wlog_data.delete();
    prev = done_count;
    start_load(3'd6, 4'd3);
    for (int i = 0; i < 12; i++) begin
      send(16'h0A00 + 16'(i));
      idle(1);
    end
    wait_done(prev);
    chk("s2_nwr", 64'(wlog_addr.size()), 64'd3);
    if (wlog_addr.size() == 3) begin
      chk("s2_addr0", 64'(wlog_addr[0]), 64'd6);
      chk("s2_addr1", 64'(wlog_addr[1]), 64'd7);
      chk("s2_addr2", 64'(wlog_addr[2]), 64'd0);
      chk("s2_data0", wlog_data[0], 64'h0A03_0A02_0A01_0A00);
      chk("s2_data1", wlog_data[1], 64'h0A07_0A06_0A05_0A04);
      chk("s2_data2", wlog_data[2], 64'h0A0B_0A0A_0A09_0A08);
    end
    idle(2);

    // Zero rows: done next cycle, no writes.
    wlog_addr.delete(); wlog_data.delete();
    prev = done_count;
    start_load(3'd2, 4'd0);
    wait_done(prev);
    chk("s3_done_lat", 64'(done_cyc - start_cyc), 64'd1);
    idle(2);
    chk("s3_nwr", 64'(wlog_addr.size()), 64'd0);
    chk("s3_busy", 64'(o_busy), 64'd0);

    // Reset mid-row discards the partial row.
    wlog_addr.delete(); wlog_data.delete();
    start_load(3'd2, 4'd1);
    send(16'h00A1); send(16'h00A2);
    i_reset = 1'b1;
    idle(1);
    i_reset = 1'b0;
    idle(3);
    chk("s4_nwr_rst", 64'(wlog_addr.size()), 64'd0);
    chk("s4_busy", 64'(o_busy), 64'd0);
    prev = done_count;
    start_load(3'd0, 4'd1);
    send(16'h00B0); send(16'h00B1); send(16'h00B2); send(16'h00B3);
    wait_done(prev);
    chk("s4_nwr", 64'(wlog_addr.size()), 64'd1);
    if (wlog_addr.size() == 1) begin
      chk("s4_addr", 64'(wlog_addr[0]), 64'd0);
      chk("s4_data", wlog_data[0], 64'h00B3_00B2_00B1_00B0);
    end
    idle(2);

    // Start during FILL is ignored.
    wlog_addr.delete(); wlog_data.delete();
    prev = done_count;
    start_load(3'd1, 4'd2);
    send(16'h0C00);
    i_start = 1'b1; i_base_addr = 3'd5; i_num_rows = 4'd1;
    send(16'h0C01);
    i_start = 1'b0;
    for (int i = 2; i < 8; i++) send(16'h0C00 + 16'(i));
    wait_done(prev);
    idle(6);
    chk("s5_ndone", 64'(done_count - prev), 64'd1);
    chk("s5_nwr", 64'(wlog_addr.size()), 64'd2);
    if (wlog_addr.size() == 2) begin
      chk("s5_addr0", 64'(wlog_addr[0]), 64'd1);
      chk("s5_addr1", 64'(wlog_addr[1]), 64'd2);
      chk("s5_data1", wlog_data[1], 64'h0C07_0C06_0C05_0C04);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mat_cache_loader.md
# mat_cache_loader

Write-side companion of the matrix cache: accepts a stream of FPSIZE-bit elements over a valid/ready handshake, packs WIDTH consecutive elements into one cache row, and issues single-cycle row writes to consecutive cache addresses starting at a programmed base. It sits between the matrix unit's data feed and the cache write port. It is the producer whose rows the cache's read port later returns as `cout`.

## Interface
- `WIDTH`, 128, elements per cache row (lanes)
- `CACHESIZE`, 256, number of row addresses in the cache
- `CACHEADDR`, $clog2(CACHESIZE), row address width
- `FPSIZE`, 16, bits per element
- `clock`  in  1  single clock; all state changes on posedge
- `reset`  in  1  synchronous, active-high
- `start`  in  1  begin a load; sampled only in IDLE
- `base_addr`  in  CACHEADDR  first row address; sampled with `start`
- `num_rows`  in  CACHEADDR+1  rows to load (0..CACHESIZE); sampled with `start`
- `in_valid`  in  1  `in_data` valid
- `in_data`  in  FPSIZE  element
- `in_ready`  out  1  loader accepts an element this cycle
- `wr_en`  out  1  cache row write strobe
- `wr_addr`  out  CACHEADDR  row address for the write
- `wr_data`  out  WIDTH x FPSIZE  packed row; lane k = k-th accepted element of the row
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse at load completion

## Operation
- States: IDLE, FILL, WRITE, DONE.
- IDLE: `in_ready`=0. `start`=1 latches `base_addr`/`num_rows`, clears lane counter `col` and row counter `row`. If `num_rows`=0, go to DONE; otherwise go to FILL.
- FILL: `in_ready`=1. On handshake (`in_valid`&&`in_ready`), store `in_data` in lane `col`, `col`++. On the handshake with `col`=WIDTH-1, go to WRITE. Cycles without `in_valid` hold all state.
- WRITE: `wr_en`=1 for exactly this cycle, `wr_addr`=(base+row) mod CACHESIZE, `wr_data`=packed buffer; `in_ready`=0. Then `row`++ and `col`=0. If `row`+1=`num_rows`, go to DONE, else go to FILL.
- DONE: `done`=1 for this cycle, then IDLE.
- Address wrap: the row address is computed in CACHEADDR bits, so base 254 with 4 rows (CACHESIZE=256) writes 254, 255, 0, 1.
- `start` outside IDLE is ignored; `base_addr`/`num_rows` changes after sampling have no effect.
- `wr_data` holds its last value when `wr_en`=0. Lanes not yet rewritten in a partial row are never written to the cache.
- Reset in any state, including mid-row: next cycle state=IDLE; `col`, `row`, and the buffer are cleared; the partial row is discarded with no write.

## Timing
- Reset values: `in_ready`=0, `wr_en`=0, `wr_addr`=0, `wr_data`=all zero, `busy`=0, `done`=0.
- All outputs are registered or decoded from state only. There is no combinational path from `in_valid` to `in_ready`.
- `start` at cycle t -> `busy`=1 and `in_ready`=1 at t+1.
- Last handshake of a row at t -> `wr_en` at t+1 -> next row's `in_ready` at t+2, or `done` at t+2 if it was the last row.
- Peak throughput: WIDTH elements per WIDTH+1 cycles.
- `num_rows`=0: `start` at t -> `done` at t+1, with no writes.

## Structure
- Package `mat_pkg`: `fp_t` (logic [FPSIZE-1:0]), `row_t` (WIDTH x fp_t), and the loader state enum. The cache read side imports the same `row_t`.
- Sub-module `mat_row_packer`: lane counter plus WIDTH x FPSIZE buffer. It has a shift-in-at-`col` enable and a clear, and produces a `full` flag. The FSM and address generation stay in `mat_cache_loader`.

## Test plan
Benches use WIDTH=4, CACHESIZE=8, FPSIZE=16.
- Reset idle: hold `reset` 2 cycles, then release -> all outputs 0; `in_valid`=1 alone produces no `in_ready`.
- Single row: start base=3, rows=1, feed 0x1111, 0x2222, 0x3333, 0x4444 back-to-back -> one `wr_en` pulse with addr 3, lanes 0..3 = 0x1111..0x4444, `done` exactly 2 cycles after the last handshake.
- Wrap and bubbles: start base=6, rows=3, with `in_valid` toggling every other cycle -> writes to addresses 6, 7, 0 in order, element order preserved, no write while rows are partial.
- Zero rows: start with `num_rows`=0 -> `done` next cycle, `wr_en` never asserted, back in IDLE.
- Reset mid-row: after 2 of 4 elements, assert `reset` -> no write occurs. A new load (base=0, rows=1) then writes only the new 4 elements.
- Ignored start: pulse `start` with base=5 during FILL -> the original load's addresses are unaffected and exactly one `done` is seen.
